core_sequencer: RTL

Parametrised multi-cycle control sequencer for the RISC-V core, replacing the fixed two-cycle memory timing of the current top-level FSM. It drives fetch, decode, execute, memory and writeback strobes to the datapath (decoder, register_file, ALU, branch unit, memory). It adds a variable-latency memory request/ready handshake, a memory timeout, a halt state, single-step mode, and latched trap cause/PC. It also provides cycle and retired-instruction counters.

---
 rtl/core_pkg.sv | 25 ++
 rtl/core_sequencer_if.sv | 11 +
 rtl/core_sequencer_mem_wait_timer.sv | 29 ++
 rtl/core_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer: state encoding, trap causes, default widths.
package core_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_FETCH      = 4'd1,
    ST_FETCH_WAIT = 4'd2,
    ST_DECODE     = 4'd3,
    ST_EXECUTE    = 4'd4,
    ST_MEM        = 4'd5,
    ST_MEM_WAIT   = 4'd6,
    ST_WRITEBACK  = 4'd7,
    ST_HALT       = 4'd8,
    ST_TRAP       = 4'd15
  } state_e;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'd1;
  localparam logic [2:0] CAUSE_FETCH   = 3'd2;
  localparam logic [2:0] CAUSE_DATA    = 3'd3;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd4;

endpackage

// File: rtl/core_sequencer_if.sv
// Memory request/ready handshake between the sequencer (master) and the memory (slave).
interface core_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;
  logic mem_err;

  modport master (output mem_req, mem_we, mem_addr_sel, input mem_ready, mem_err);
  modport slave  (input mem_req, mem_we, mem_addr_sel, output mem_ready, mem_err);
endinterface

// File: rtl/core_sequencer_mem_wait_timer.sv
// Memory wait timeout: down-counter loaded on clear, expires on the last allowed waiting cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= W'(MEM_TIMEOUT);
    end else if (run && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // run is only high on cycles without ready, so a ready on the limit cycle never expires
  assign expired = run && (cnt == W'(1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute/mem/writeback strobes with
// variable-latency memory handshake, timeout, halt, single-step and trap capture.
//
// state       | meaning
// ------------+-------------------------------------------------
// IDLE        | waiting for start (or step in step mode)
// FETCH       | issue instruction fetch request
// FETCH_WAIT  | hold fetch request until mem_ready
// DECODE      | evaluate decoder flags
// EXECUTE     | latch ALU operands
// MEM         | issue data request
// MEM_WAIT    | hold data request until mem_ready
// WRITEBACK   | register write, PC update, retire
// HALT        | EBREAK seen, waiting for start
// TRAP        | fault latched, only reset exits
module core_sequencer
  import core_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic [XLEN-1:0]   pc,
  input  logic              decode_error,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              is_halt,
  core_sequencer_if.master  mem,
  output logic              ir_we,
  output logic              alu_en,
  output logic              reg_we,
  output logic              pc_we,
  output logic [3:0]        state,
  output logic              trap_valid,
  output logic [2:0]        trap_cause,
  output logic [XLEN-1:0]   trap_pc,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count
);

  state_e     state_q, state_d;
  logic [2:0] cause_d;
  logic       wait_run, wait_clear, wait_expired;

  assign wait_clear = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign wait_run   = ((state_q == ST_FETCH_WAIT) || (state_q == ST_MEM_WAIT)) && !mem.mem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear),
    .run     (wait_run),
    .expired (wait_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cause_d = CAUSE_NONE;
    case (state_q)
      ST_IDLE:       if (step_mode ? step : start) state_d = ST_FETCH;
      ST_FETCH:      state_d = ST_FETCH_WAIT;
      ST_FETCH_WAIT: begin
        if (mem.mem_ready) begin
          if (mem.mem_err) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_FETCH;
          end else begin
            state_d = ST_DECODE;
          end
        end else if (wait_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (decode_error) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (is_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE:    state_d = (is_load || is_store) ? ST_MEM : ST_WRITEBACK;
      ST_MEM:        state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (mem.mem_ready) begin
          if (mem.mem_err) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_DATA;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end else if (wait_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WRITEBACK:  state_d = step_mode ? ST_IDLE : ST_FETCH;
      ST_HALT:       if (start) state_d = ST_FETCH;
      ST_TRAP:       state_d = ST_TRAP;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_we            = 1'b0;
    alu_en           = 1'b0;
    reg_we           = 1'b0;
    pc_we            = 1'b0;
    case (state_q)
      ST_FETCH:      mem.mem_req = 1'b1;
      ST_FETCH_WAIT: begin
        mem.mem_req = 1'b1;
        ir_we       = mem.mem_ready && !mem.mem_err;
      end
      ST_EXECUTE:    alu_en = 1'b1;
      ST_MEM, ST_MEM_WAIT: begin
        mem.mem_req      = 1'b1;
        mem.mem_addr_sel = 1'b1;
        mem.mem_we       = is_store;
      end
      ST_WRITEBACK: begin
        reg_we = !is_store;
        pc_we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trap_valid <= 1'b0;
      trap_cause <= CAUSE_NONE;
      trap_pc    <= '0;
    end else if (state_d == ST_TRAP && state_q != ST_TRAP) begin
      trap_valid <= 1'b1;
      trap_cause <= cause_d;
      trap_pc    <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (!(state_q inside {ST_IDLE, ST_HALT, ST_TRAP})) cycle_count <= cycle_count + CNT_W'(1);
      if (state_q == ST_WRITEBACK) instret_count <= instret_count + CNT_W'(1);
    end
  end

endmodule
